traffic_phase_ctrl: RTL and testbench

Parametrised multi-approach traffic signal controller, the successor to the fixed three-lamp `traffic` block. It sequences NUM_DIR approaches through all-red, green and yellow phases with programmable durations. It adds a latched pedestrian walk phase, a flash override and a run/pause enable. It sits directly on the lamp drivers; all outputs are registered.

---
 rtl/traffic_phase_ctrl.sv | 160 ++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - round-robin multi-approach signal sequencer with flash override
// Pedestrian walk phase and request latch are built only when TRAFFIC_PED_EN is defined.
module traffic_phase_ctrl #(
    parameter int NUM_DIR    = 2,
    parameter int GREEN_CYC  = 20,
    parameter int YELLOW_CYC = 4,
    parameter int ALLRED_CYC = 2,
    parameter int WALK_CYC   = 10,
    parameter int FLASH_HALF = 8,
    parameter int CNT_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       flash_req,
    input  logic                       ped_req,
    output logic [NUM_DIR-1:0]         red,
    output logic [NUM_DIR-1:0]         yellow,
    output logic [NUM_DIR-1:0]         green,
    output logic                       walk,
    output logic                       ped_ack,
    output logic [$clog2(NUM_DIR)-1:0] active_dir
);
    localparam int DW = $clog2(NUM_DIR);

    typedef enum logic [2:0] {S_ALLRED, S_GREEN, S_YELLOW, S_WALK, S_FLASH} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   timer, timer_d;
    logic [DW-1:0]      dir_d, next_dir, next_dir_d;
    logic               flash_on, flash_on_d;
    logic               ped_go;
    logic [NUM_DIR-1:0] hot, red_d, yellow_d, green_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_ALLRED;
            timer      <= CNT_W'(ALLRED_CYC - 1);
            active_dir <= '0;
            next_dir   <= '0;
            flash_on   <= 1'b0;
            red        <= '1;
            yellow     <= '0;
            green      <= '0;
        end else begin
            state      <= state_d;
            timer      <= timer_d;
            active_dir <= dir_d;
            next_dir   <= next_dir_d;
            flash_on   <= flash_on_d;
            red        <= red_d;
            yellow     <= yellow_d;
            green      <= green_d;
        end
    end

    // Flash entry bypasses en; everything else advances only on enabled cycles.
    always_comb begin
        state_d    = state;
        timer_d    = timer;
        dir_d      = active_dir;
        next_dir_d = next_dir;
        flash_on_d = flash_on;
        if (flash_req) begin
            if (state != S_FLASH) begin
                state_d    = S_FLASH;
                timer_d    = CNT_W'(FLASH_HALF - 1);
                flash_on_d = 1'b1;
            end else if (en) begin
                if (timer == '0) begin
                    timer_d    = CNT_W'(FLASH_HALF - 1);
                    flash_on_d = ~flash_on;
                end else begin
                    timer_d = timer - CNT_W'(1);
                end
            end
        end else if (en) begin
            if (state == S_FLASH) begin
                state_d    = S_ALLRED;
                timer_d    = CNT_W'(ALLRED_CYC - 1);
                next_dir_d = '0;
            end else if (timer != '0) begin
                timer_d = timer - CNT_W'(1);
            end else begin
                case (state)
                    S_ALLRED: begin
                        if (ped_go) begin
                            state_d = S_WALK;
                            timer_d = CNT_W'(WALK_CYC - 1);
                        end else begin
                            state_d = S_GREEN;
                            timer_d = CNT_W'(GREEN_CYC - 1);
                            dir_d   = next_dir;
                        end
                    end
                    S_GREEN: begin
                        state_d = S_YELLOW;
                        timer_d = CNT_W'(YELLOW_CYC - 1);
                    end
                    S_YELLOW: begin
                        state_d    = S_ALLRED;
                        timer_d    = CNT_W'(ALLRED_CYC - 1);
                        next_dir_d = (active_dir == DW'(NUM_DIR - 1)) ? '0 : active_dir + DW'(1);
                    end
                    default: begin
                        state_d = S_ALLRED;
                        timer_d = CNT_W'(ALLRED_CYC - 1);
                    end
                endcase
            end
        end
    end

    // Lamps are decoded from the next state so they register on the same edge.
    always_comb begin
        hot      = {{(NUM_DIR-1){1'b0}}, 1'b1} << dir_d;
        red_d    = '1;
        yellow_d = '0;
        green_d  = '0;
        case (state_d)
            S_GREEN: begin
                green_d = hot;
                red_d   = ~hot;
            end
            S_YELLOW: begin
                yellow_d = hot;
                red_d    = ~hot;
            end
            S_FLASH: red_d = {NUM_DIR{flash_on_d}};
            default: red_d = '1;
        endcase
    end

`ifdef TRAFFIC_PED_EN
    logic ped_pending, ped_pending_d, walk_entry;

    assign ped_go        = ped_pending;
    assign walk_entry    = (state_d == S_WALK) && (state != S_WALK);
    assign ped_pending_d = (ped_pending & ~walk_entry) | ped_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_pending <= 1'b0;
            walk        <= 1'b0;
            ped_ack     <= 1'b0;
        end else begin
            ped_pending <= ped_pending_d;
            walk        <= (state_d == S_WALK);
            ped_ack     <= walk_entry;
        end
    end
`else
    logic unused_ped_req;

    assign unused_ped_req = ped_req;
    assign ped_go         = 1'b0;
    assign walk           = 1'b0;
    assign ped_ack        = 1'b0;
`endif
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - randomized check of traffic_phase_ctrl against a phase-level model
module tb_traffic_phase_ctrl;
    localparam int GC = 20, YC = 4, AC = 2, WC = 10, FH = 8;
`ifdef TRAFFIC_PED_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif
    localparam int P_AR = 0, P_G = 1, P_Y = 2, P_W = 3, P_F = 4;

    typedef struct packed {
        int ph;
        int left;
        int dir;
        int nxt;
        bit ped;
        bit lit;
        bit ack;
    } mdl_t;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b1, flash_req = 1'b0, ped_req = 1'b0;
    logic [1:0] red2, yellow2, green2;
    logic [3:0] red4, yellow4, green4;
    logic       walk2, ack2, walk4, ack4;
    logic [0:0] dir2;
    logic [1:0] dir4;
    int         n_tests = 0, n_fail = 0;
    mdl_t       m2, m4;

    traffic_phase_ctrl u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .flash_req(flash_req), .ped_req(ped_req),
        .red(red2), .yellow(yellow2), .green(green2), .walk(walk2), .ped_ack(ack2),
        .active_dir(dir2)
    );

    traffic_phase_ctrl #(.NUM_DIR(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .flash_req(flash_req), .ped_req(ped_req),
        .red(red4), .yellow(yellow4), .green(green4), .walk(walk4), .ped_ack(ack4),
        .active_dir(dir4)
    );

    always #5 clk = ~clk;

    function automatic mdl_t m_reset();
        mdl_t r;
        r.ph = P_AR; r.left = AC; r.dir = 0; r.nxt = 0;
        r.ped = 1'b0; r.lit = 1'b0; r.ack = 1'b0;
        return r;
    endfunction

    // 'left' counts the cycles still to be shown in the current phase, including this one.
    function automatic mdl_t step(input mdl_t m, input int nd, input bit en_i, input bit fr, input bit pr);
        mdl_t r = m;
        r.ack = 1'b0;
        if (fr) begin
            if (m.ph != P_F) begin
                r.ph = P_F; r.left = FH; r.lit = 1'b1;
            end else if (en_i) begin
                if (m.left == 1) begin r.lit = !m.lit; r.left = FH; end
                else r.left = m.left - 1;
            end
        end else if (en_i) begin
            if (m.ph == P_F) begin
                r.ph = P_AR; r.left = AC; r.nxt = 0;
            end else if (m.left > 1) begin
                r.left = m.left - 1;
            end else begin
                case (m.ph)
                    P_AR: if (PED && m.ped) begin
                        r.ph = P_W; r.left = WC; r.ped = 1'b0; r.ack = 1'b1;
                    end else begin
                        r.ph = P_G; r.left = GC; r.dir = m.nxt;
                    end
                    P_G: begin r.ph = P_Y; r.left = YC; end
                    P_Y: begin r.ph = P_AR; r.left = AC; r.nxt = (m.dir + 1) % nd; end
                    default: begin r.ph = P_AR; r.left = AC; end
                endcase
            end
        end
        if (PED && pr) r.ped = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m2 <= m_reset();
            m4 <= m_reset();
        end else begin
            m2 <= step(m2, 2, en, flash_req, ped_req);
            m4 <= step(m4, 4, en, flash_req, ped_req);
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_unit(input string pfx, input mdl_t m, input int nd,
                              input int r, input int y, input int g,
                              input int w, input int a, input int d);
        int all, hot, er, ey, eg;
        all = (1 << nd) - 1;
        hot = 1 << m.dir;
        er = all; ey = 0; eg = 0;
        if (m.ph == P_G) begin eg = hot; er = all & ~hot; end
        if (m.ph == P_Y) begin ey = hot; er = all & ~hot; end
        if (m.ph == P_F) er = m.lit ? all : 0;
        check_eq({pfx, ".red"}, r, er);
        check_eq({pfx, ".yellow"}, y, ey);
        check_eq({pfx, ".green"}, g, eg);
        check_eq({pfx, ".walk"}, w, int'(PED && m.ph == P_W));
        check_eq({pfx, ".ped_ack"}, a, int'(m.ack));
        check_eq({pfx, ".active_dir"}, d, m.dir);
        check_eq({pfx, ".onehot"}, int'($countones(g | y) <= 1), 1);
    endtask

    task automatic check_all();
        check_unit("d2", m2, 2, int'(red2), int'(yellow2), int'(green2),
                   int'(walk2), int'(ack2), int'(dir2));
        check_unit("d4", m4, 4, int'(red4), int'(yellow4), int'(green4),
                   int'(walk4), int'(ack4), int'(dir4));
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_lamp(input string tag, input bit want_yellow);
        int k = 0;
        while (((want_yellow ? yellow2 : green2) == 2'b00) && k < 200) begin
            tick();
            k++;
        end
        check_eq(tag, int'(k < 200), 1);
    endtask

    initial begin
        int first = -1, second = -1, flash_cnt = 0;
        bit prev = 1'b0;

        tick();
        tick();
        rst_n = 1'b1;

        for (int c = 1; c <= 130; c++) begin
            tick();
            if (green2[0] && !prev) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            prev = green2[0];
        end
        check_eq("first_green_edge", first, 2);
        check_eq("round_length", second - first, 52);

        wait_lamp("wait_yellow", 1'b1);
        tick();
        en = 1'b0;
        repeat (15) tick();
        en = 1'b1;
        repeat (10) tick();

        wait_lamp("wait_green", 1'b0);
        repeat (5) tick();
        flash_req = 1'b1;
        repeat (40) tick();
        flash_req = 1'b0;
        repeat (40) tick();

        wait_lamp("wait_green_ped", 1'b0);
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        repeat (60) tick();
        ped_req = 1'b1;
        repeat (80) tick();
        ped_req = 1'b0;

        repeat (3000) begin
            en = ($urandom_range(0, 7) != 0);
            if (flash_cnt > 0) begin
                flash_cnt--;
                flash_req = 1'b1;
            end else begin
                flash_req = 1'b0;
                if ($urandom_range(0, 299) == 0) flash_cnt = $urandom_range(1, 40);
            end
            ped_req = ($urandom_range(0, 29) == 0);
            tick();
        end

        en = 1'b1; flash_req = 1'b0; ped_req = 1'b0;
        repeat (13) tick();
        #2 rst_n = 1'b0;
        #1 check_all();
        tick();
        rst_n = 1'b1;
        repeat (60) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
